// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: address/bus widths, constant words
// and the layout of a prediction-queue entry.
package branch_resolver_pkg;

  localparam int AddrLen  = 32;
  localparam int PredSize = 4;

  localparam logic [AddrLen-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Entry packing is {pc, is_btype, pred_jump, pred_pc}; CtlW covers the two flag bits.
  localparam int CtlW = 2;

  function automatic int entry_width(input int addr_w);
    return (2 * addr_w) + CtlW;
  endfunction

endpackage

// File: rtl/pred_queue.sv
// Generic DEPTH-entry circular FIFO with push, pop and a synchronous clear that
// overrides both. Head data is presented combinationally on rdata.
module pred_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer/count state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; data needs no reset because count gates its visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[tail_q] <= wdata;
    end
  end

  assign rdata = mem[head_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued IF predictions against EX outcomes, raising flush/redirect and
// predictor training. Define BRANCH_STATS_EN to build the br_cnt/mis_cnt counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W = AddrLen,
  parameter int DEPTH  = 4,
  parameter int BUS_W  = PredSize
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_push,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_is_btype,
  input  logic              if_pred_jump,
  input  logic [ADDR_W-1:0] if_pred_pc,
  output logic              q_full,
  output logic              q_ovf,
  input  logic              ex_valid,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              is_btype,
  output logic              jump_or_not,
  output logic [BUS_W-1:0]  ex_pc_bus,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       br_cnt,
  output logic [31:0]       mis_cnt
);

  localparam int EW = entry_width(ADDR_W);

  logic [EW-1:0]          head_s;
  logic [$clog2(DEPTH):0] count_s;
  logic                   full_s;
  logic [ADDR_W-1:0]      h_pc_s, h_ppc_s, redirect_s;
  logic                   h_isb_s, h_pj_s;
  logic                   pop_s, mis_s, push_s, ovf_set_s;

  logic              flush_q, flush_d, isb_q, isb_d, jon_q, jon_d, ovf_q, ovf_d;
  logic [BUS_W-1:0]  bus_q, bus_d;
  logic [ADDR_W-1:0] redir_q, redir_d;

  pred_queue #(.DEPTH(DEPTH), .WIDTH(EW)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (mis_s),
    .wdata ({if_pc, if_is_btype, if_pred_jump, if_pred_pc}),
    .rdata (head_s),
    .full  (full_s),
    .count (count_s)
  );

  assign h_ppc_s = head_s[ADDR_W-1:0];
  assign h_pj_s  = head_s[ADDR_W];
  assign h_isb_s = head_s[ADDR_W+1];
  assign h_pc_s  = head_s[EW-1:ADDR_W+2];

  // A full queue can still accept a push when the head is popping the same cycle;
  // a mispredict discards any same-cycle push as wrong-path.
  assign pop_s      = rdy && ex_valid && (count_s != '0);
  assign mis_s      = pop_s && ((ex_taken != h_pj_s) || (ex_taken && (ex_target != h_ppc_s)));
  assign push_s     = rdy && if_push && (!full_s || ex_valid) && !mis_s;
  assign ovf_set_s  = rdy && if_push && full_s && !ex_valid;
  assign redirect_s = ex_taken ? ex_target : (h_pc_s + ADDR_W'(4));

  // Output next state: flush/is_btype are single-cycle pulses, the rest hold.
  always_comb begin
    flush_d = False;
    isb_d   = False;
    jon_d   = jon_q;
    bus_d   = bus_q;
    redir_d = redir_q;
    ovf_d   = ovf_q;
    if (rdy) begin
      ovf_d = ovf_q | ovf_set_s;
      if (pop_s && h_isb_s) begin
        isb_d = True;
        jon_d = ex_taken;
        bus_d = h_pc_s[BUS_W+1:2];
      end else begin
        isb_d = False;
      end
      if (mis_s) begin
        flush_d = True;
        redir_d = redirect_s;
      end else begin
        flush_d = False;
      end
    end else begin
      flush_d = False;
      isb_d   = False;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_q <= 1'b0;
      isb_q   <= 1'b0;
      jon_q   <= 1'b0;
      bus_q   <= '0;
      redir_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      flush_q <= flush_d;
      isb_q   <= isb_d;
      jon_q   <= jon_d;
      bus_q   <= bus_d;
      redir_q <= redir_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_full      = full_s;
  assign q_ovf       = ovf_q;
  assign flush       = flush_q;
  assign is_btype    = isb_q;
  assign jump_or_not = jon_q;
  assign ex_pc_bus   = bus_q;
  assign redirect_pc = redir_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  // Saturating statistics; pop_s already folds in rdy so both hold while stalled.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (pop_s && h_isb_s && (br_cnt_q != 32'hFFFF_FFFF)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end else begin
      br_cnt_d = br_cnt_q;
    end
    if (mis_s && (mis_cnt_q != 32'hFFFF_FFFF)) begin
      mis_cnt_d = mis_cnt_q + 32'd1;
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt_q  <= ZERO_WORD;
      mis_cnt_q <= ZERO_WORD;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`else
  assign br_cnt  = ZERO_WORD;
  assign mis_cnt = ZERO_WORD;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst, rdy, if_push, if_is_btype, if_pred_jump, ex_valid, ex_taken;
  logic [31:0] if_pc, if_pred_pc, ex_target;
  logic        q_full, q_ovf, is_btype, jump_or_not, flush;
  logic [3:0]  ex_pc_bus;
  logic [31:0] redirect_pc, br_cnt, mis_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic        isb;
    logic        pj;
    logic [31:0] ppc;
  } ent_t;

  ent_t        mq[$];
  logic        m_ovf, m_flush, m_isb, m_jon;
  logic [3:0]  m_bus;
  logic [31:0] m_redir;
  int          m_br, m_mis;

  always #5 clk = ~clk;

  branch_resolver #(.ADDR_W(32), .DEPTH(4), .BUS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_push(if_push), .if_pc(if_pc), .if_is_btype(if_is_btype),
    .if_pred_jump(if_pred_jump), .if_pred_pc(if_pred_pc),
    .q_full(q_full), .q_ovf(q_ovf),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .is_btype(is_btype), .jump_or_not(jump_or_not), .ex_pc_bus(ex_pc_bus),
    .flush(flush), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  // Reference behaviour at one clock edge, from the inputs present at that edge.
  task automatic model_edge();
    ent_t e;
    bit   was_full, mis;
    mis = 1'b0;
    if (!rst) begin
      mq.delete();
      m_ovf = 0; m_flush = 0; m_isb = 0; m_jon = 0; m_bus = 0; m_redir = 0;
      m_br = 0; m_mis = 0;
    end else if (!rdy) begin
      m_flush = 0; m_isb = 0;
    end else begin
      was_full = (mq.size() == 4);
      m_flush = 0; m_isb = 0;
      if (if_push && was_full && !ex_valid) m_ovf = 1;
      if (ex_valid && mq.size() > 0) begin
        e = mq.pop_front();
        if (e.isb) begin
          m_isb = 1; m_jon = ex_taken; m_bus = e.pc[5:2]; m_br++;
        end
        mis = (ex_taken != e.pj) || (ex_taken && ex_target != e.ppc);
        if (mis) begin
          m_flush = 1;
          m_redir = ex_taken ? ex_target : e.pc + 32'd4;
          m_mis++;
          mq.delete();
        end
      end
      if (if_push && (!was_full || ex_valid) && !mis)
        mq.push_back('{if_pc, if_is_btype, if_pred_jump, if_pred_pc});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    if_push = 0; if_pc = 0; if_is_btype = 0; if_pred_jump = 0; if_pred_pc = 0;
    ex_valid = 0; ex_taken = 0; ex_target = 0; rdy = 1;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic isb, input logic pj, input logic [31:0] ppc);
    if_push = 1; if_pc = pc; if_is_btype = isb; if_pred_jump = pj; if_pred_pc = ppc;
  endtask

  task automatic set_ex(input logic tk, input logic [31:0] tgt);
    ex_valid = 1; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic do_reset();
    idle(); rst = 0; step(); step(); rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    set_push(32'h100, 1, 1, 32'h140); set_ex(0, 32'h0);
    step(); step();
    rst = 1; idle();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0h expected 0", flush); end
    checks++; if (is_btype !== 1'b0) begin errors++; $display("FAIL reset_isb: got %0h expected 0", is_btype); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redir: got %0h expected 0", redirect_pc); end
    checks++; if ({q_full, q_ovf, jump_or_not} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %0h expected 0", {q_full, q_ovf, jump_or_not}); end
    checks++; if (ex_pc_bus !== 4'h0) begin errors++; $display("FAIL reset_bus: got %0h expected 0", ex_pc_bus); end
    checks++; if ({br_cnt, mis_cnt} !== 64'h0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", {br_cnt, mis_cnt}); end
    // The pushed entry must have been discarded: a lone ex_valid does nothing.
    set_ex(0, 32'h0); step(); idle();
    checks++; if (flush !== 1'b0 || is_btype !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0h expected 0", {flush, is_btype}); end
  endtask

  task automatic test_predictions();
    do_reset();
    set_push(32'h100, 1, 1, 32'h140); step(); idle();
    set_ex(1, 32'h140); step(); idle();
    checks++; if ({flush, is_btype, jump_or_not} !== 3'b011) begin errors++; $display("FAIL correct_taken: got %0h expected 3", {flush, is_btype, jump_or_not}); end
    checks++; if (ex_pc_bus !== 4'h0) begin errors++; $display("FAIL correct_bus: got %0h expected 0", ex_pc_bus); end
    set_push(32'h204, 1, 1, 32'h240); step(); idle();
    set_ex(0, 32'h0); step(); idle();
    checks++; if ({flush, is_btype, jump_or_not} !== 3'b110) begin errors++; $display("FAIL mis_nt: got %0h expected 6", {flush, is_btype, jump_or_not}); end
    checks++; if (redirect_pc !== 32'h208) begin errors++; $display("FAIL mis_nt_redir: got %0h expected 208", redirect_pc); end
    checks++; if (ex_pc_bus !== 4'h1) begin errors++; $display("FAIL mis_nt_bus: got %0h expected 1", ex_pc_bus); end
    set_ex(1, 32'h0); step(); idle();
    checks++; if ({flush, is_btype} !== 2'b00) begin errors++; $display("FAIL empty_pop: got %0h expected 0", {flush, is_btype}); end
    set_push(32'h300, 0, 1, 32'h400); step(); idle();
    set_ex(1, 32'h404); step(); idle();
    checks++; if ({flush, is_btype} !== 2'b10) begin errors++; $display("FAIL jal_mis: got %0h expected 2", {flush, is_btype}); end
    checks++; if (redirect_pc !== 32'h404) begin errors++; $display("FAIL jal_redir: got %0h expected 404", redirect_pc); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_bus [4] = '{4'h5, 4'h6, 4'h7, 4'hB};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_push(32'h10 + 32'(i * 4), 1, 0, 32'h0); step();
    end
    idle();
    checks++; if (q_full !== 1'b1 || q_ovf !== 1'b0) begin errors++; $display("FAIL fill: got %0h expected 2", {q_full, q_ovf}); end
    set_push(32'h20, 1, 0, 32'h0); step(); idle();
    checks++; if (q_full !== 1'b1 || q_ovf !== 1'b1) begin errors++; $display("FAIL ovf: got %0h expected 3", {q_full, q_ovf}); end
    set_push(32'h52C, 1, 0, 32'h0); set_ex(0, 32'h0); step(); idle();
    checks++; if (q_full !== 1'b1 || ex_pc_bus !== 4'h4 || flush !== 1'b0) begin errors++; $display("FAIL push_pop_full: got full=%0h bus=%0h flush=%0h expected 1 4 0", q_full, ex_pc_bus, flush); end
    for (int i = 0; i < 4; i++) begin
      set_ex(0, 32'h0); step(); idle();
      checks++; if (ex_pc_bus !== exp_bus[i] || is_btype !== 1'b1) begin errors++; $display("FAIL drain%0d: got %0h expected %0h", i, ex_pc_bus, exp_bus[i]); end
    end
    checks++; if (q_full !== 1'b0 || q_ovf !== 1'b1) begin errors++; $display("FAIL drained: got %0h expected 1", {q_full, q_ovf}); end
  endtask

  task automatic test_mispredict_push();
    do_reset();
    set_push(32'h700, 1, 1, 32'h740); step(); idle();
    set_push(32'h704, 1, 0, 32'h0); set_ex(0, 32'h0); step(); idle();
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h704) begin errors++; $display("FAIL mis_push: got %0h/%0h expected 1/704", flush, redirect_pc); end
    set_ex(0, 32'h0); step(); idle();
    checks++; if ({flush, is_btype} !== 2'b00) begin errors++; $display("FAIL wrong_path_dropped: got %0h expected 0", {flush, is_btype}); end
  endtask

  task automatic test_rdy_stall();
    int pulses = 0;
    do_reset();
    set_push(32'h600, 1, 1, 32'h640); step(); idle();
    set_ex(0, 32'h0); step(); pulses += flush;
    rdy = 0;
    for (int i = 0; i < 3; i++) begin step(); pulses += flush; end
    idle(); step(); pulses += flush;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL rdy_pulse: got %0d expected 1", pulses); end
    checks++; if (redirect_pc !== 32'h604) begin errors++; $display("FAIL rdy_redir: got %0h expected 604", redirect_pc); end
    rdy = 0; set_push(32'h800, 1, 0, 32'h0); step(); idle();
    set_ex(1, 32'h0); step(); idle();
    checks++; if ({flush, is_btype} !== 2'b00) begin errors++; $display("FAIL rdy_push_frozen: got %0h expected 0", {flush, is_btype}); end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_push(32'h1000 + 32'(i * 4), 1, 1, 32'h800); step(); idle();
      set_ex((i == 1 || i == 3) ? 1'b0 : 1'b1, 32'h800); step(); idle();
    end
    set_push(32'h2000, 0, 1, 32'h900); step(); idle();
    set_ex(1, 32'h900); step(); idle();
`ifdef BRANCH_STATS_EN
    checks++; if (br_cnt !== 32'd5) begin errors++; $display("FAIL br_cnt: got %0d expected 5", br_cnt); end
    checks++; if (mis_cnt !== 32'd2) begin errors++; $display("FAIL mis_cnt: got %0d expected 2", mis_cnt); end
`else
    checks++; if (br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin errors++; $display("FAIL stats_tied: got %0d/%0d expected 0/0", br_cnt, mis_cnt); end
`endif
  endtask

  task automatic test_random();
    ent_t h;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 79) != 0);
      rdy = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) begin
        if_pc = 32'($urandom_range(0, 1023)) << 2;
        set_push(if_pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? if_pc + 32'h40 : 32'($urandom));
      end
      if ($urandom_range(0, 2) != 0) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
          h = mq[0];
          set_ex(h.pj, h.ppc);
        end else if (mq.size() > 0) begin
          h = mq[0];
          set_ex(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? h.ppc : h.ppc + 32'h4);
        end else begin
          set_ex(1'($urandom_range(0, 1)), 32'($urandom));
        end
      end
      step();
      checks++; if (flush !== m_flush) begin errors++; $display("FAIL rnd_flush@%0d: got %0h expected %0h", n, flush, m_flush); end
      checks++; if (redirect_pc !== m_redir) begin errors++; $display("FAIL rnd_redir@%0d: got %0h expected %0h", n, redirect_pc, m_redir); end
      checks++; if ({is_btype, jump_or_not, ex_pc_bus} !== {m_isb, m_jon, m_bus}) begin errors++; $display("FAIL rnd_train@%0d: got %0h expected %0h", n, {is_btype, jump_or_not, ex_pc_bus}, {m_isb, m_jon, m_bus}); end
      checks++; if (q_full !== (mq.size() == 4) || q_ovf !== m_ovf) begin errors++; $display("FAIL rnd_q@%0d: got %0h expected %0h", n, {q_full, q_ovf}, {mq.size() == 4, m_ovf}); end
`ifdef BRANCH_STATS_EN
      checks++; if (br_cnt !== 32'(m_br) || mis_cnt !== 32'(m_mis)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", n, br_cnt, mis_cnt, m_br, m_mis); end
`endif
    end
    rst = 1; idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_predictions();
    test_overflow();
    test_mispredict_push();
    test_rdy_stall();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
